// File: rtl/vga_pkg.sv
// vga_pkg: screen geometry, pixel field widths and arbiter state encodings shared across the VGA path
package vga_pkg;
  localparam int XW    = 9;
  localparam int YW    = 8;
  localparam int CW    = 9;
  localparam int X_MAX = 319;
  localparam int Y_MAX = 239;
  typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first set request searching circularly from ptr+1
module rr_pick #(
  parameter int N = 4,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] c;
  always_comb begin
    idx = '0;
    c   = '0;
    // walk from farthest to nearest so the nearest candidate after ptr wins
    for (int k = N; k >= 1; k--) begin
      c = IW'((int'(ptr) + k) % N);
      if (req[c]) idx = c;
    end
    win = |req ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: round-robin burst-locked sharing of the VGA adapter pixel-write port
// with on-screen clipping and a grant timeout.
module vga_write_arbiter import vga_pkg::*; #(
  parameter int NUM_REQ   = 4,
  parameter int XW        = vga_pkg::XW,
  parameter int YW        = vga_pkg::YW,
  parameter int CW        = vga_pkg::CW,
  parameter int X_MAX     = vga_pkg::X_MAX,
  parameter int Y_MAX     = vga_pkg::Y_MAX,
  parameter int MAX_BURST = 1024
) (
  input  logic                  CLOCK_50,
  input  logic                  Reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    px_valid,
  input  logic [NUM_REQ-1:0]    px_last,
  input  logic [NUM_REQ*XW-1:0] px_x,
  input  logic [NUM_REQ*YW-1:0] px_y,
  input  logic [NUM_REQ*CW-1:0] px_colour,
  output logic [NUM_REQ-1:0]    grant,
  output logic [XW-1:0]         VGA_x,
  output logic [YW-1:0]         VGA_y,
  output logic [CW-1:0]         VGA_colour,
  output logic                  plot,
  output logic                  busy,
  output logic                  timeout_err
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST);
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, win;
  logic [IW-1:0] g_q, g_d, rr_ptr_q, rr_ptr_d, widx;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] x_q, x_d, sx;
  logic [YW-1:0] y_q, y_d, sy;
  logic [CW-1:0] colour_q, colour_d, sc;
  logic plot_q, plot_d, terr_q, terr_d, accept, rel, tmo;

  rr_pick #(.N(NUM_REQ)) u_pick (.req(req), .ptr(rr_ptr_q), .win(win), .idx(widx));

  assign sx     = px_x[g_q*XW +: XW];
  assign sy     = px_y[g_q*YW +: YW];
  assign sc     = px_colour[g_q*CW +: CW];
  assign accept = grant_q[g_q] & px_valid[g_q];
  assign rel    = state_q == GRANT && ((accept && px_last[g_q]) || !req[g_q]);
  // a real release on the final counted cycle takes precedence over the timeout
  assign tmo    = state_q == GRANT && cnt_q == BW'(MAX_BURST - 1) && !rel;

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      g_q      <= '0;
      rr_ptr_q <= IW'(NUM_REQ - 1);
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      g_q      <= g_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      terr_q   <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q == IDLE ? (|req ? GRANT : IDLE) : (rel || tmo ? IDLE : GRANT);
  end

  always_comb begin
    grant_d  = state_q == IDLE ? win : (rel || tmo ? '0 : grant_q);
    g_d      = state_q == IDLE ? widx : g_q;
    rr_ptr_d = rel || tmo ? g_q : rr_ptr_q;
    cnt_d    = state_q == GRANT ? cnt_q + 1'b1 : '0;
    x_d      = accept ? sx : x_q;
    y_d      = accept ? sy : y_q;
    colour_d = accept ? sc : colour_q;
    plot_d   = accept && sx <= XW'(X_MAX) && sy <= YW'(Y_MAX);
    terr_d   = tmo;
  end

  assign grant       = grant_q;
  assign VGA_x       = x_q;
  assign VGA_y       = y_q;
  assign VGA_colour  = colour_q;
  assign plot        = plot_q;
  assign busy        = |grant_q;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_vga_write_arbiter.sv
// tb_vga_write_arbiter: directed vectors with hand-computed expectations for vga_write_arbiter
module tb_vga_write_arbiter;
  logic CLOCK_50 = 1'b0, Reset = 1'b1;
  logic [3:0] req = '0, px_valid = '0, px_last = '0;
  logic [3:0][8:0] px_x = '0;
  logic [3:0][7:0] px_y = '0;
  logic [3:0][8:0] px_colour = '0;
  logic [3:0] grant;
  logic [8:0] VGA_x, VGA_colour;
  logic [7:0] VGA_y;
  logic plot, busy, timeout_err;
  int n_cmp = 0, n_bad = 0;

  vga_write_arbiter #(.NUM_REQ(4), .MAX_BURST(16)) dut (
    .CLOCK_50(CLOCK_50), .Reset(Reset), .req(req), .px_valid(px_valid), .px_last(px_last),
    .px_x(px_x), .px_y(px_y), .px_colour(px_colour), .grant(grant), .VGA_x(VGA_x),
    .VGA_y(VGA_y), .VGA_colour(VGA_colour), .plot(plot), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic pix(input int i, input int x, input int y, input int c, input logic last);
    px_valid[i]  = 1'b1;
    px_last[i]   = last;
    px_x[i]      = 9'(x);
    px_y[i]      = 8'(y);
    px_colour[i] = 9'(c);
  endtask

  initial begin
    #3;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_plot", 32'(plot), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    chk("rst_xy", 32'({VGA_x, VGA_y, VGA_colour}), 0);
    Reset = 1'b0;
    step;
    // single burst of three pixels from requester 0
    req = 4'b0001;
    step;
    chk("t1_grant", 32'(grant), 32'b0001);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_noplot", 32'(plot), 0);
    pix(0, 10, 20, 'h1FF, 1'b0);
    step;
    chk("t1_p0", 32'({plot, VGA_x, VGA_y, VGA_colour}), {1'b1, 9'd10, 8'd20, 9'h1FF});
    pix(0, 11, 20, 'h1FF, 1'b0);
    step;
    chk("t1_p1", 32'({plot, VGA_x}), {1'b1, 9'd11});
    pix(0, 12, 20, 'h1FF, 1'b1);
    step;
    chk("t1_p2", 32'({plot, VGA_x}), {1'b1, 9'd12});
    chk("t1_rel", 32'({grant, busy}), 0);
    req = '0; px_valid = '0; px_last = '0;
    step;
    chk("t1_idle_plot", 32'(plot), 0);
    // fresh reset so requester 0 leads the fair rotation
    #2 Reset = 1'b1;
    #1 Reset = 1'b0;
    req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      step;
      chk("t2_grant", 32'(grant), 32'(1 << (b % 4)));
      pix(b % 4, 100 + b, 50, b, 1'b0);
      step;
      pix(b % 4, 200 + b, 50, b, 1'b1);
      step;
      chk("t2_dead", 32'({grant, busy}), 0);
      chk("t2_x", 32'({plot, VGA_x}), {1'b1, 9'(200 + b)});
      px_valid = '0; px_last = '0;
    end
    // clipping: requester 1 after requester 0 was last served
    req = 4'b0010;
    step;
    chk("t3_grant", 32'(grant), 32'b0010);
    pix(1, 320, 5, 1, 1'b0);
    step;
    chk("t3_offx", 32'({plot, VGA_x}), {1'b0, 9'd320});
    pix(1, 5, 240, 2, 1'b0);
    step;
    chk("t3_offy", 32'({plot, VGA_y}), {1'b0, 8'd240});
    pix(1, 319, 239, 3, 1'b1);
    step;
    chk("t3_edge", 32'({plot, VGA_x, VGA_y}), {1'b1, 9'd319, 8'd239});
    px_valid = '0; px_last = '0; req = '0;
    step;
    // timeout: requester 2 never sends last, requester 3 waits
    req = 4'b0100;
    step;
    chk("t4_grant", 32'(grant), 32'b0100);
    req = 4'b1100;
    for (int i = 2; i <= 16; i++) step;
    chk("t4_held16", 32'({grant, timeout_err}), {4'b0100, 1'b0});
    step;
    chk("t4_revoke", 32'({grant, busy, timeout_err}), {4'b0000, 1'b0, 1'b1});
    step;
    chk("t4_next", 32'({grant, timeout_err}), {4'b1000, 1'b0});
    req = '0;
    step;
    chk("t4_drop", 32'(grant), 0);
    // asynchronous reset in the middle of requester 1's burst
    req = 4'b0010;
    step;
    chk("t5_grant", 32'(grant), 32'b0010);
    pix(1, 7, 8, 9, 1'b0);
    step;
    chk("t5_plot", 32'(plot), 1);
    Reset = 1'b1;
    #1;
    chk("t5_async", 32'({grant, plot, busy, VGA_x}), 0);
    Reset = 1'b0;
    px_valid = '0; req = 4'b0011;
    step;
    chk("t5_prio0", 32'(grant), 32'b0001);
    // non-granted requester's pixels are ignored
    pix(0, 50, 60, 'h0AA, 1'b0);
    pix(1, 100, 100, 'h155, 1'b0);
    step;
    chk("t6_own", 32'({plot, VGA_x, VGA_y, VGA_colour}), {1'b1, 9'd50, 8'd60, 9'h0AA});
    px_valid[0] = 1'b0;
    px_x[1] = 9'd101;
    step;
    chk("t6_ignore", 32'({plot, VGA_x, VGA_colour}), {1'b0, 9'd50, 9'h0AA});
    pix(0, 51, 61, 'h0AB, 1'b1);
    step;
    chk("t6_last", 32'({plot, VGA_x, grant}), {1'b1, 9'd51, 4'b0000});
    px_valid = '0; px_last = '0;
    step;
    chk("t6_next1", 32'(grant), 32'b0010);
    // request drop coinciding with a valid pixel: pixel still lands
    req = '0;
    pix(1, 9, 9, 'h011, 1'b0);
    step;
    chk("t6_droppix", 32'({plot, VGA_x, grant}), {1'b1, 9'd9, 4'b0000});
    px_valid = '0;
    step;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vga_write_arbiter.md
Name: vga_write_arbiter

Overview:
Shares the single pixel-write port of the VGA adapter between up to NUM_REQ object drawers: player ship, enemies, projectiles and the background eraser.
- Arbitration is round-robin with burst lock. A granted drawer keeps the port until it flags its last pixel, drops its request, or exceeds a timeout.
- Accepted pixels are clipped to the screen and registered onto the adapter's x/y/colour/plot inputs.
- Sits between the per-object drawing FSMs and vga_adapter inside vga_demo.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
XW, 9, x coordinate width
YW, 8, y coordinate width
CW, 9, colour width (3 bits per channel)
X_MAX, 319, largest visible x
Y_MAX, 239, largest visible y
MAX_BURST, 1024, grant timeout in cycles (power of two not required)

Ports:
CLOCK_50  in  1  system clock, all state on rising edge
Reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester port request, level
px_valid  in  NUM_REQ  pixel presented this cycle
px_last  in  NUM_REQ  presented pixel is the final one of the burst
px_x  in  NUM_REQ*XW  packed x, requester i at [i*XW +: XW]
px_y  in  NUM_REQ*YW  packed y
px_colour  in  NUM_REQ*CW  packed colour
grant  out  NUM_REQ  one-hot grant, registered; doubles as pixel-ready
VGA_x  out  XW  registered x to adapter
VGA_y  out  YW  registered y
VGA_colour  out  CW  registered colour
plot  out  1  registered write strobe
busy  out  1  a grant is active
timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset values: all outputs 0 (timeout_err included); state IDLE; rr_ptr = NUM_REQ-1, so requester 0 wins first; burst counter 0.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any req is set, pick the first set bit searching circularly from rr_ptr+1.
  - Next edge: grant that one-hot bit, busy=1, state GRANT, counter cleared.
  - If no req is set, stay in IDLE.
- GRANT, pixel acceptance:
  - A pixel from requester g is accepted on an edge where grant[g] & px_valid[g].
  - px_valid, px_last and data of non-granted requesters are ignored.
- GRANT, output timing:
  - An accepted pixel appears on VGA_x/VGA_y/VGA_colour on the following cycle. Latency is 1.
  - plot=1 on that cycle only if x<=X_MAX and y<=Y_MAX.
  - Off-screen pixels are still accepted but plot=0 (clipped).
  - Non-accept cycles drive plot=0; coordinates hold their last value.
- GRANT, release:
  - Release when an accepted pixel has px_last=1, or when req[g] is 0.
  - On release: grant and busy go to 0 at the next edge, rr_ptr<=g, state IDLE.
  - IDLE always lasts at least one cycle between bursts (one dead cycle).
- GRANT, timeout:
  - The counter increments every GRANT cycle.
  - When the counter reaches MAX_BURST-1 without a release, release as above and pulse timeout_err for exactly one cycle.
- Simultaneous events:
  - px_last accept together with the timeout cycle counts as a normal release; no timeout_err.
  - req drop together with a px_valid on the same cycle: the pixel is still accepted, then release.
- Starvation: with all requesters continuously requesting, grant order is 0,1,2,3,0,...
- Reset mid-burst:
  - Grant, plot and counter clear immediately (asynchronous).
  - The in-flight registered pixel is discarded.
  - After deassertion, requester 0 has priority.
- Widths: counter width is $clog2(MAX_BURST); compares are unsigned.

Decomposition:
- Shared package/header `vga_pkg`: XW, YW, CW, X_MAX, Y_MAX and the IDLE/GRANT state encodings, reused by the drawers and vga_adapter.
- Natural sub-module: `rr_pick`, combinational round-robin selector. Inputs req and rr_ptr; outputs one-hot winner and index.

Test Plan:
- Reset, then req=0001, 3 valid pixels (10,20,0x1FF),(11,20,0x1FF),(12,20,0x1FF) with last on the third.
  - grant=0001 one cycle after req.
  - plot pulses on 3 consecutive cycles, each 1 cycle after accept.
  - grant=0 after the third; busy falls.
- req=1111 held, each burst of 2 pixels.
  - Grant sequence 0001,0010,0100,1000,0001.
  - Exactly one dead IDLE cycle between grants.
- Granted requester sends (320,5) then (5,240) then (319,239,last).
  - Outputs: plot=0, plot=0, plot=1 with VGA_x=319, VGA_y=239.
- MAX_BURST=16, requester 2 holds req with no last.
  - Grant revoked after 16 cycles; timeout_err high exactly one cycle.
  - Next pending requester 3 granted.
- Assert Reset for 1 ns mid-burst of requester 1.
  - Grant, plot and busy go to 0 immediately.
  - After release with req=0011, requester 0 is granted first.
- Requester 0 granted; requester 1 pulses px_valid with data.
  - No plot from requester 1; VGA outputs reflect only requester 0's pixels.
